// File: rtl/halflife_pkg.sv
// Shared definitions for the halving-decay controller.
// Holds the FSM state encoding, the default prescaler width and counter limits.
// No logic; imported by the controller and its prescaler.
package halflife_pkg;

  localparam int PERIOD_W_DEFAULT = 8;

  // Largest value the 4-bit datapath counter can hold.
  localparam logic [3:0] CNT_MAX = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_WAIT = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/halflife_prescaler.sv
// Half-period prescaler: counts enabled cycles and flags the last one of a period.
// Terminal count is combinational from the current count; clear takes effect next cycle.
// No backpressure; clear has priority over enable.
module halflife_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic         tc
);

  logic [W-1:0] count;

  // Count enabled cycles; clear restarts the period from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // period is never 0 here: the controller latches max(half_period, 1).
  assign tc = en && (count == (period - W'(1)));

endmodule

// File: rtl/halflife_ctrl.sv
// Halving-decay controller: drives load/up/down strobes so an external counter halves per period.
// Strobes are combinational from state, one cycle per action; LOAD lasts exactly one cycle.
// No backpressure; abort or reset masks strobes in the same cycle and returns to IDLE.
module halflife_ctrl
  import halflife_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                boost,
  input  logic [3:0]          init_val,
  input  logic [PERIOD_W-1:0] half_period,
  output logic                cnt_load,
  output logic [3:0]          cnt_in,
  output logic                cnt_up,
  output logic                cnt_down,
  output logic                busy,
  output logic                done,
  output logic [3:0]          halvings
);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          init_lat;
  logic [PERIOD_W-1:0] period_lat;
  logic [3:0]          shadow;     // mirrors the datapath counter, no feedback needed
  logic [3:0]          remaining;  // down pulses left in the current halving
  logic [3:0]          halv_r;
  logic                pre_clr;
  logic                pre_en;
  logic                pre_tc;

  halflife_prescaler #(.W(PERIOD_W)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (pre_clr),
    .en     (pre_en),
    .period (period_lat),
    .tc     (pre_tc)
  );

  // Prescaler runs only while waiting; restart it on load, expiry and abort.
  always_comb begin
    pre_en  = (state == ST_WAIT);
    pre_clr = (state == ST_LOAD) || ((state == ST_WAIT) && pre_tc) || abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe decode; abort/reset suppress every strobe this cycle.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_up    = 1'b0;
    cnt_down  = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        cnt_load  = 1'b1;
        state_nxt = (init_lat != 4'd0) ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        if (pre_tc) begin
          state_nxt = ST_STEP;
        end else if (boost && (shadow != CNT_MAX)) begin
          cnt_up = 1'b1;
        end
      end
      ST_STEP: begin
        cnt_down = 1'b1;
        if (remaining == 4'd1) begin
          state_nxt = (shadow == 4'd1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_DONE: if (start) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
    end
    if (abort || rst) begin
      cnt_load = 1'b0;
      cnt_up   = 1'b0;
      cnt_down = 1'b0;
    end
  end

  // Run bookkeeping: latch parameters at start, track shadow count and halvings.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_lat   <= '0;
      period_lat <= '0;
      shadow     <= '0;
      remaining  <= '0;
      halv_r     <= '0;
    end else if (abort) begin
      halv_r <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            init_lat   <= init_val;
            period_lat <= (half_period == '0) ? PERIOD_W'(1) : half_period;
          end
        end
        ST_LOAD: begin
          shadow    <= init_lat;
          remaining <= '0;
          halv_r    <= '0;
        end
        ST_WAIT: begin
          if (pre_tc) begin
            remaining <= shadow - (shadow >> 1);
          end else if (cnt_up) begin
            shadow <= shadow + 4'd1;
          end
        end
        ST_STEP: begin
          shadow    <= shadow - 4'd1;
          remaining <= remaining - 4'd1;
          if ((remaining == 4'd1) && (halv_r != CNT_MAX)) begin
            halv_r <= halv_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt_in   = cnt_load ? init_lat : 4'd0;
  assign busy     = (state == ST_LOAD) || (state == ST_WAIT) || (state == ST_STEP);
  assign done     = (state == ST_DONE);
  assign halvings = halv_r;

endmodule

// File: doc/halflife_ctrl.md
HALFLIFE_CTRL -- requirements
Module: halflife_ctrl

Interface
REQ-001 Parameter PERIOD_W, default 8: width of the half-period tick count.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  begin a decay run; sampled in IDLE and DONE only.
REQ-005 abort  input  1  cancel the current run; return to IDLE.
REQ-006 boost  input  1  request +1 on the counter while waiting.
REQ-007 init_val  input  4  starting count.
REQ-008 half_period  input  PERIOD_W  clk cycles per halving; 0 treated as 1.
REQ-009 cnt_load  output  1  one-cycle load strobe to the counter datapath.
REQ-010 cnt_in  output  4  load value; equals init_val latched at start, else 0.
REQ-011 cnt_up  output  1  one-cycle increment strobe to the datapath.
REQ-012 cnt_down  output  1  one-cycle decrement strobe to the datapath.
REQ-013 busy  output  1  high in LOAD, WAIT and STEP.
REQ-014 done  output  1  level, high in DONE.
REQ-015 halvings  output  4  completed halvings this run, saturating at 15.

Function
REQ-016 States: IDLE, LOAD, WAIT, STEP, DONE; strobes are decoded from state and masked to 0 in any cycle with abort=1.
REQ-017 IDLE: all strobes 0; start=1 -> LOAD, latching init_val and max(half_period,1).
REQ-018 LOAD: exactly one cycle; cnt_load=1, cnt_in=latched init_val; shadow<=init_val, prescaler<=0, halvings<=0; next WAIT if init_val!=0, else DONE.
REQ-019 WAIT: prescaler increments each cycle; in the cycle it equals period-1: remaining<=shadow-(shadow>>1), prescaler<=0, next STEP.
REQ-020 WAIT boost: boost=1 and shadow<15 and not the expiry cycle -> cnt_up=1 this cycle, shadow+1; boost at shadow=15 ignored; expiry takes precedence over boost (boost dropped).
REQ-021 STEP: cnt_down=1 every cycle; shadow and remaining decrement each cycle; boost ignored.
REQ-022 STEP exit: in the cycle remaining==1, halvings increments (saturating); next DONE if shadow==1, else WAIT with prescaler=0.
REQ-023 Each halving therefore emits exactly ceil(shadow/2) consecutive cnt_down pulses; the datapath value after it equals floor(previous/2).
REQ-024 DONE: done=1, busy=0, strobes 0, halvings held; start=1 -> LOAD (restart); abort -> IDLE.
REQ-025 start while busy is ignored; half_period and init_val changes mid-run have no effect.
REQ-026 abort=1 in any state -> IDLE next cycle, halvings cleared, no strobe in the abort cycle.
REQ-027 At most one of cnt_load, cnt_up, cnt_down is high in any cycle.
REQ-028 The shadow value equals the datapath counter value in every cycle after LOAD; the block uses no feedback from the datapath.

Reset
REQ-029 rst=1 -> next state IDLE; shadow, remaining, prescaler, halvings, latched registers cleared; all outputs 0.
REQ-030 rst overrides start, abort and boost in the same cycle; reset mid-STEP emits no further cnt_down.

Structure
REQ-031 Shared package halflife_pkg holds the state enumeration and the PERIOD_W default.
REQ-032 One sub-module halflife_prescaler (period counter with clear, enable and terminal-count output); FSM, shadow and halving logic stay in halflife_ctrl.

Verification
REQ-033 init_val=12, half_period=3, start pulse -> 1 cnt_load (cnt_in=12); down bursts of 6,3,2,1 pulses, each preceded by 3 WAIT cycles; done=1, halvings=4; 12 cnt_down total.
REQ-034 init_val=0, start -> one cnt_load with cnt_in=0, then DONE next cycle, halvings=0, zero cnt_down pulses.
REQ-035 init_val=15, half_period=0 -> period 1; bursts of 8,4,2,1 pulses separated by single WAIT cycles; halvings=4.
REQ-036 init_val=8, half_period=4, boost on WAIT cycle 1 -> cnt_up=1, then burst of 5 pulses (9->4); boost in the expiry cycle -> no cnt_up.
REQ-037 abort during third pulse of a burst -> no cnt_down that cycle, IDLE next, halvings=0; start during WAIT -> ignored.
REQ-038 rst asserted mid-STEP -> all outputs 0 the next cycle; subsequent start performs a clean LOAD.
